// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and widths for controller, physics and render
package game_pkg;

    localparam int SCORE_W     = 4;
    localparam int FRAME_CNT_W = 8;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_RALLY  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } game_state_e;

    // A zero-length timer would never expire cleanly, so it is stretched to one frame.
    function automatic logic [FRAME_CNT_W-1:0] frames_min1(input logic [FRAME_CNT_W-1:0] v);
        return (v == '0) ? FRAME_CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - frame-based down counter shared by the serve and point timers
module frame_countdown
    import game_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [FRAME_CNT_W-1:0] load_val_i,
    input  logic                   tick_i,
    output logic [FRAME_CNT_W-1:0] count_o,
    output logic                   expire_o
);

    logic [FRAME_CNT_W-1:0] count_q;

    // Stops at 1 rather than wrapping; a tick at 1 or 0 is reported as expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= frames_min1(load_val_i);
        end else if (tick_i && (count_q > FRAME_CNT_W'(1))) begin
            count_q <= count_q - FRAME_CNT_W'(1);
        end
    end

    assign count_o  = count_q;
    assign expire_o = tick_i && (count_q <= FRAME_CNT_W'(1));

endmodule

// File: rtl/rally_controller.sv
// rtl/rally_controller.sv - match sequencer: serve, rally, pause, point and match-over flow
module rally_controller
    import game_pkg::*;
#(
    parameter logic [SCORE_W-1:0]     WIN_SCORE    = 4'd7,
    parameter logic [FRAME_CNT_W-1:0] SERVE_FRAMES = 8'd60,
    parameter logic [FRAME_CNT_W-1:0] PAUSE_FRAMES = 8'd90
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   start_btn,
    input  logic                   pause_btn,
    input  logic                   p1_jump,
    input  logic                   p2_jump,
    input  logic                   p1_point,
    input  logic                   p2_point,
    input  logic [SCORE_W-1:0]     p1_score,
    input  logic [SCORE_W-1:0]     p2_score,
    output logic                   phys_step,
    output logic                   ball_hold,
    output logic                   score_clr,
    output logic                   serve_side,
    output logic [2:0]             state_o,
    output logic [FRAME_CNT_W-1:0] countdown,
    output logic                   match_over,
    output logic                   winner
);

    game_state_e            state_q;
    logic                   cnt_tick, cnt_expire, cnt_load, cnt_clr;
    logic [FRAME_CNT_W-1:0] cnt_load_val;
    logic                   start_ev, point_ev, serve_go, point_exp, over_ev;
    logic                   p1_wins, p2_wins, server_jump, bad_state;

    assign bad_state   = (state_q > ST_OVER);
    assign start_ev    = start_btn && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign point_ev    = (p1_point || p2_point) && (state_q == ST_RALLY);
    assign server_jump = (serve_side == SIDE_P2) ? p2_jump : p1_jump;
    assign serve_go    = (state_q == ST_SERVE) && (cnt_expire || server_jump);
    assign point_exp   = (state_q == ST_POINT) && cnt_expire;
    assign p1_wins     = (p1_score >= WIN_SCORE);
    assign p2_wins     = (p2_score >= WIN_SCORE);
    assign over_ev     = point_exp && (p1_wins || p2_wins);

    // The counter only runs in SERVE/POINT and is zeroed on every exit into another state.
    assign cnt_tick     = frame_tick && ((state_q == ST_SERVE) || (state_q == ST_POINT));
    assign cnt_load     = start_ev || point_ev || (point_exp && !over_ev);
    assign cnt_load_val = point_ev ? PAUSE_FRAMES : SERVE_FRAMES;
    assign cnt_clr      = serve_go || over_ev || bad_state;

    frame_countdown u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .tick_i     (cnt_tick),
        .count_o    (countdown),
        .expire_o   (cnt_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phys_step  <= 1'b0;
            ball_hold  <= 1'b1;
            score_clr  <= 1'b0;
            serve_side <= SIDE_P1;
            match_over <= 1'b0;
            winner     <= SIDE_P1;
        end else begin
            phys_step <= 1'b0;
            score_clr <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_btn) begin
                        state_q    <= ST_SERVE;
                        score_clr  <= 1'b1;
                        serve_side <= SIDE_P1;
                        match_over <= 1'b0;
                        ball_hold  <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (serve_go) begin
                        state_q   <= ST_RALLY;
                        ball_hold <= 1'b0;
                    end
                end
                ST_RALLY: begin
                    // A point outranks both pause and the frame's physics step.
                    if (point_ev) begin
                        state_q    <= ST_POINT;
                        ball_hold  <= 1'b1;
                        serve_side <= p1_point ? SIDE_P1 : SIDE_P2;
                    end else if (pause_btn) begin
                        state_q <= ST_PAUSED;
                    end else begin
                        phys_step <= frame_tick;
                    end
                end
                ST_PAUSED: begin
                    if (pause_btn) begin
                        state_q <= ST_RALLY;
                    end
                end
                ST_POINT: begin
                    if (point_exp) begin
                        if (p1_wins) begin
                            state_q    <= ST_OVER;
                            match_over <= 1'b1;
                            winner     <= SIDE_P1;
                        end else if (p2_wins) begin
                            state_q    <= ST_OVER;
                            match_over <= 1'b1;
                            winner     <= SIDE_P2;
                        end else begin
                            state_q <= ST_SERVE;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ball_hold  <= 1'b1;
                    match_over <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_rally_controller.sv
// tb/tb_rally_controller.sv - scoreboard bench for rally_controller with a rule-level reference model
module tb_rally_controller;

    localparam int P_IDLE = 0, P_SERVE = 1, P_RALLY = 2, P_PAUSED = 3, P_POINT = 4, P_OVER = 5;
    localparam int SERVE_F = 60, PAUSE_F = 90, WIN = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
    logic       p1_jump = 1'b0, p2_jump = 1'b0, p1_point = 1'b0, p2_point = 1'b0;
    logic [3:0] p1_score = 4'd0, p2_score = 4'd0;
    logic       phys_step, ball_hold, score_clr, serve_side, match_over, winner;
    logic [2:0] state_o;
    logic [7:0] countdown;

    always #5 clk = ~clk;

    rally_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .p1_jump    (p1_jump),
        .p2_jump    (p2_jump),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .phys_step  (phys_step),
        .ball_hold  (ball_hold),
        .score_clr  (score_clr),
        .serve_side (serve_side),
        .state_o    (state_o),
        .countdown  (countdown),
        .match_over (match_over),
        .winner     (winner)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       step;
        logic       hold;
        logic       clr;
        logic       side;
        logic [7:0] cd;
        logic       over;
        logic       win;
    } obs_t;

    obs_t sb[$];
    int   checks = 0, errors = 0;
    bit   mon_on = 0;

    // Reference model: game phase, frames left on the current timer, and last-cycle events.
    int ph = P_IDLE, tmr = 0;
    bit m_side = 0, m_win = 0, m_step = 0, m_clr = 0;

    // Inputs requested for the next cycle; pulses are cleared after each cycle.
    bit       n_rst = 0, n_ft = 0, n_st = 0, n_pb = 0, n_j1 = 0, n_j2 = 0, n_pt1 = 0, n_pt2 = 0;
    bit [3:0] n_s1 = 0, n_s2 = 0;

    task automatic model_step();
        m_step = 0;
        m_clr  = 0;
        if (!rst_n) begin
            ph = P_IDLE; tmr = 0; m_side = 0; m_win = 0;
            return;
        end
        case (ph)
            P_IDLE, P_OVER: if (start_btn) begin
                ph = P_SERVE; tmr = SERVE_F; m_side = 0; m_clr = 1;
            end
            P_SERVE: begin
                if ((frame_tick && tmr <= 1) || (m_side ? p2_jump : p1_jump)) begin
                    ph = P_RALLY; tmr = 0;
                end else if (frame_tick) tmr = tmr - 1;
            end
            P_RALLY: begin
                if (p1_point)       begin ph = P_POINT; m_side = 0; tmr = PAUSE_F; end
                else if (p2_point)  begin ph = P_POINT; m_side = 1; tmr = PAUSE_F; end
                else if (pause_btn) ph = P_PAUSED;
                else                m_step = frame_tick;
            end
            P_PAUSED: if (pause_btn) ph = P_RALLY;
            P_POINT: if (frame_tick) begin
                if (tmr > 1) tmr = tmr - 1;
                else if (p1_score >= WIN) begin ph = P_OVER; m_win = 0; tmr = 0; end
                else if (p2_score >= WIN) begin ph = P_OVER; m_win = 1; tmr = 0; end
                else begin ph = P_SERVE; tmr = SERVE_F; end
            end
            default: ph = P_IDLE;
        endcase
    endtask

    function automatic obs_t expected();
        obs_t e;
        e.st   = 3'(ph);
        e.step = m_step;
        e.hold = (ph != P_RALLY) && (ph != P_PAUSED);
        e.clr  = m_clr;
        e.side = m_side;
        e.cd   = (ph == P_SERVE || ph == P_POINT) ? 8'(tmr) : 8'd0;
        e.over = (ph == P_OVER);
        e.win  = m_win;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        rst_n = n_rst; frame_tick = n_ft; start_btn = n_st; pause_btn = n_pb;
        p1_jump = n_j1; p2_jump = n_j2; p1_point = n_pt1; p2_point = n_pt2;
        p1_score = n_s1; p2_score = n_s2;
        model_step();
        sb.push_back(expected());
        mon_on = 1;
        n_ft = 0; n_st = 0; n_pb = 0; n_pt1 = 0; n_pt2 = 0;
    endtask

    task automatic tick_frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            n_ft = 1;
            step();
            repeat (gap) step();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        obs_t got, exp_o;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                got = '{state_o, phys_step, ball_hold, score_clr, serve_side, countdown, match_over, winner};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty at %0t", $time);
                end else begin
                    exp_o = sb.pop_front();
                    if (got !== exp_o) begin
                        errors++;
                        $display("FAIL sb_cycle t=%0t got st=%0d step=%b hold=%b clr=%b side=%b cd=%0d over=%b win=%b expected st=%0d step=%b hold=%b clr=%b side=%b cd=%0d over=%b win=%b",
                                 $time, got.st, got.step, got.hold, got.clr, got.side, got.cd, got.over, got.win,
                                 exp_o.st, exp_o.step, exp_o.hold, exp_o.clr, exp_o.side, exp_o.cd, exp_o.over, exp_o.win);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        n_rst = 0;
        step(); step();
        chk("reset_state", state_o, P_IDLE);
        chk("reset_hold", ball_hold, 1);
        chk("reset_cd", countdown, 0);
        chk("reset_flags", {phys_step, score_clr, serve_side, match_over, winner}, 0);
        n_rst = 1;
        step();

        n_st = 1; step(); step();
        chk("start_state", state_o, P_SERVE);
        chk("start_cd", countdown, SERVE_F);
        chk("start_clr", score_clr, 1);
        step();
        chk("clr_one_cycle", score_clr, 0);

        tick_frames(59, 1);
        chk("serve_cd_last", countdown, 1);
        tick_frames(1, 1);
        chk("serve_expiry", state_o, P_RALLY);
        chk("rally_cd", countdown, 0);
        n_ft = 1; step(); step();
        chk("step_latency", phys_step, 1);
        step();
        chk("step_width", phys_step, 0);

        n_pt2 = 1; step(); step();
        chk("p2_point_state", state_o, P_POINT);
        chk("p2_point_side", serve_side, 1);
        chk("point_cd", countdown, PAUSE_F);
        tick_frames(90, 1);
        chk("point_to_serve", state_o, P_SERVE);
        chk("point_serve_cd", countdown, SERVE_F);

        tick_frames(60, 0);
        n_pt1 = 1; step(); step();
        n_s1 = 4'd7; step();
        tick_frames(90, 0);
        step();
        chk("over_state", state_o, P_OVER);
        chk("over_flag", match_over, 1);
        chk("over_winner", winner, 0);
        n_st = 1; step(); step();
        chk("restart_state", state_o, P_SERVE);
        chk("restart_clr", score_clr, 1);
        chk("restart_over", match_over, 0);
        n_s1 = 0;

        tick_frames(20, 0);
        step();
        chk("jump_cd", countdown, 40);
        n_j2 = 1; step(); step();
        chk("wrong_jump", state_o, P_SERVE);
        n_j2 = 0; n_j1 = 1; step(); step();
        chk("server_jump", state_o, P_RALLY);
        n_j1 = 0;

        n_pb = 1; step(); step();
        chk("pause_enter", state_o, P_PAUSED);
        for (int i = 0; i < 10; i++) begin
            n_ft = 1;
            if (i == 5) n_pt1 = 1;
            step(); step();
        end
        chk("pause_hold", state_o, P_PAUSED);
        n_pb = 1; step(); step();
        chk("pause_exit", state_o, P_RALLY);
        n_ft = 1; step(); step();
        chk("step_resume", phys_step, 1);

        n_ft = 1; n_pt1 = 1; n_pt2 = 1; step(); step();
        chk("simul_state", state_o, P_POINT);
        chk("simul_side", serve_side, 0);
        chk("simul_no_step", phys_step, 0);
        tick_frames(3, 1);
        n_rst = 0; step();
        #1;
        chk("async_reset_state", state_o, P_IDLE);
        chk("async_reset_cd", countdown, 0);
        chk("async_reset_hold", ball_hold, 1);
        chk("async_reset_flags", {phys_step, score_clr, serve_side, match_over, winner}, 0);
        n_rst = 1; step();

        for (int c = 0; c < 15000; c++) begin
            n_ft  = ($urandom % 3) == 0;
            n_st  = ($urandom % 200) == 0;
            n_pb  = ($urandom % 150) == 0;
            n_pt1 = ($urandom % 60) == 0;
            n_pt2 = ($urandom % 60) == 0;
            if (($urandom % 40) == 0) n_j1 = ~n_j1;
            if (($urandom % 40) == 0) n_j2 = ~n_j2;
            if (($urandom % 50) == 0) n_s1 = 4'($urandom % 10);
            if (($urandom % 50) == 0) n_s2 = 4'($urandom % 10);
            n_rst = ($urandom % 3000) != 0;
            step();
        end

        @(posedge clk);
        #2;
        mon_on = 0;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
